// File: rtl/rd0_pixel_unpack_pkg.sv
// rtl/rd0_pixel_unpack_pkg.sv - sizing helpers and configuration check for the channel-0 pixel unpacker
package rd0_pixel_unpack_pkg;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int lanes_per_word(input int in_w, input int pix_w);
    return in_w / pix_w;
  endfunction

  // Word must split into whole pixels, and a line must end on a word boundary.
  function automatic bit cfg_ok(input int in_w, input int pix_w, input int h_pix);
    return (pix_w > 0) && (in_w >= pix_w) && ((in_w % pix_w) == 0) &&
           ((h_pix % (in_w / pix_w)) == 0);
  endfunction

endpackage

// File: rtl/rd0_raster_cnt.sv
// rtl/rd0_raster_cnt.sv - raster x/y position, sof/eol tags and frame completion pulse
module rd0_raster_cnt
  import rd0_pixel_unpack_pkg::*;
#(
  parameter int c_H_PIXELS = 1280,
  parameter int c_V_LINES  = 720,
  parameter int X_W        = clog2_min1(c_H_PIXELS),
  parameter int Y_W        = clog2_min1(c_V_LINES)
) (
  input  logic rd_clk,
  input  logic rd_rst,
  input  logic frame_sync,
  input  logic acc,
  input  logic pix_vld,
  output logic pix_sof,
  output logic pix_eol,
  output logic frame_done
);

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           x_last;
  logic           y_last;

  assign x_last  = (x == X_W'(c_H_PIXELS - 1));
  assign y_last  = (y == Y_W'(c_V_LINES - 1));
  assign pix_sof = pix_vld & (x == '0) & (y == '0);
  assign pix_eol = pix_vld & x_last;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
    end else if (frame_sync) begin
      // A restart abandons the current frame, so it never reports completion.
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= acc & x_last & y_last;
      if (acc) begin
        if (x_last) begin
          x <= '0;
          y <= y_last ? '0 : y + Y_W'(1);
        end else begin
          x <= x + X_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/rd0_pixel_unpack.sv
// rtl/rd0_pixel_unpack.sv - pops FWFT FIFO words and serialises them into a tagged pixel stream
module rd0_pixel_unpack
  import rd0_pixel_unpack_pkg::*;
#(
  parameter int c_IN_WIDTH  = 32,
  parameter int c_PIX_WIDTH = 16,
  parameter int c_H_PIXELS  = 1280,
  parameter int c_V_LINES   = 720
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic                   frame_sync,
  input  logic [c_IN_WIDTH-1:0]  fifo_data,
  input  logic                   fifo_vld,
  output logic                   fifo_en,
  output logic [c_PIX_WIDTH-1:0] pix_data,
  output logic                   pix_vld,
  input  logic                   pix_rdy,
  output logic                   pix_sof,
  output logic                   pix_eol,
  output logic                   frame_done
);

  localparam int N      = lanes_per_word(c_IN_WIDTH, c_PIX_WIDTH);
  localparam int LANE_W = clog2_min1(N);
  localparam int X_W    = clog2_min1(c_H_PIXELS);
  localparam int Y_W    = clog2_min1(c_V_LINES);

  generate
    if (!cfg_ok(c_IN_WIDTH, c_PIX_WIDTH, c_H_PIXELS)) begin : g_cfg_err
      $error("rd0_pixel_unpack: c_IN_WIDTH must be a multiple of c_PIX_WIDTH and c_H_PIXELS a multiple of the lane count");
    end
  endgenerate

  logic [c_IN_WIDTH-1:0] hold_data;
  logic                  hold_vld;
  logic [LANE_W-1:0]     lane;
  logic                  acc;
  logic                  last;

  assign pix_vld = hold_vld;
  assign acc     = hold_vld & pix_rdy;
  assign last    = (lane == LANE_W'(N - 1));
  // Reload on the last-lane accept keeps one pixel per clock across word boundaries.
  assign fifo_en = fifo_vld & ~frame_sync & (~hold_vld | (acc & last));

  always_comb begin
    pix_data = '0;
    for (int i = 0; i < N; i++) begin
      if (lane == LANE_W'(i)) begin
        pix_data = hold_data[i*c_PIX_WIDTH +: c_PIX_WIDTH];
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      hold_data <= '0;
      hold_vld  <= 1'b0;
      lane      <= '0;
    end else if (frame_sync) begin
      hold_vld <= 1'b0;
      lane     <= '0;
    end else if (fifo_en) begin
      hold_data <= fifo_data;
      hold_vld  <= 1'b1;
      lane      <= '0;
    end else if (acc & ~last) begin
      lane <= lane + LANE_W'(1);
    end else if (acc) begin
      hold_vld <= 1'b0;
    end
  end

  rd0_raster_cnt #(
    .c_H_PIXELS (c_H_PIXELS),
    .c_V_LINES  (c_V_LINES),
    .X_W        (X_W),
    .Y_W        (Y_W)
  ) u_raster (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .frame_sync (frame_sync),
    .acc        (acc),
    .pix_vld    (pix_vld),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_rd0_pixel_unpack.sv
// tb/tb_rd0_pixel_unpack.sv - vector table, corner sequences and randomized model check of rd0_pixel_unpack
module tb_rd0_pixel_unpack;

  localparam int IW = 32;
  localparam int PW = 16;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int NL = IW / PW;

  logic          rd_clk;
  logic          rd_rst;
  logic          frame_sync;
  logic [IW-1:0] fifo_data;
  logic          fifo_vld;
  logic          fifo_en;
  logic [PW-1:0] pix_data;
  logic          pix_vld;
  logic          pix_rdy;
  logic          pix_sof;
  logic          pix_eol;
  logic          frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  rd0_pixel_unpack #(
    .c_IN_WIDTH  (IW),
    .c_PIX_WIDTH (PW),
    .c_H_PIXELS  (H),
    .c_V_LINES   (V)
  ) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .frame_sync (frame_sync),
    .fifo_data  (fifo_data),
    .fifo_vld   (fifo_vld),
    .fifo_en    (fifo_en),
    .pix_data   (pix_data),
    .pix_vld    (pix_vld),
    .pix_rdy    (pix_rdy),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .frame_done (frame_done)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  typedef struct {
    logic          fv;
    logic [IW-1:0] fd;
    logic          rdy;
    logic          fs;
    logic          fen;
    logic          vld;
    logic [PW-1:0] pd;
    logic          sof;
    logic          eol;
    logic          fdn;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [IW-1:0] fd, input logic rdy, input logic fs);
    @(posedge rd_clk);
    #1;
    rd_rst     = 1'b0;
    fifo_vld   = fv;
    fifo_data  = fd;
    pix_rdy    = rdy;
    frame_sync = fs;
    @(negedge rd_clk);
  endtask

  task automatic step(input logic fv, input logic [IW-1:0] fd, input logic rdy, input logic fs,
                      input logic fen, input logic vld, input logic [PW-1:0] pd,
                      input logic sof, input logic eol, input logic fdn, input string tag);
    drive(fv, fd, rdy, fs);
    chk({tag, "_fifo_en"}, fifo_en, fen);
    chk({tag, "_pix_vld"}, pix_vld, vld);
    if (vld) chk({tag, "_pix_data"}, pix_data, pd);
    chk({tag, "_sof"}, pix_sof, sof);
    chk({tag, "_eol"}, pix_eol, eol);
    chk({tag, "_frame_done"}, frame_done, fdn);
  endtask

  task automatic resync();
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  logic [PW-1:0] exp_pix [$];
  logic [IW-1:0] fq [$];
  logic [IW-1:0] w;
  logic          e_vld, e_fen, e_acc, e_fd;
  int            pos;

  initial begin
    rd_rst = 1'b1; frame_sync = 1'b0; fifo_vld = 1'b0; fifo_data = '0; pix_rdy = 1'b1;

    for (int r = 0; r < 2; r++) begin
      @(posedge rd_clk);
      #1;
      @(negedge rd_clk);
      chk("rst_fifo_en", fifo_en, 1'b0);
    end
    chk("rst_pix_vld", pix_vld, 1'b0);
    chk("rst_pix_data", pix_data, '0);
    chk("rst_sof", pix_sof, 1'b0);
    chk("rst_eol", pix_eol, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);

    //            fv    fd             rdy   fs    fen   vld   pd      sof   eol   fdn
    tbl[0]  = '{1'b1, 32'h0002_0001, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'h0004_0003, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 32'h0004_0003, 1'b1, 1'b0, 1'b1, 1'b1, 16'h2, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 32'h0006_0005, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 32'h0006_0005, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 32'h0008_0007, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 32'h0008_0007, 1'b1, 1'b0, 1'b1, 1'b1, 16'h6, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 16'h7, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 16'h8, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].fv, tbl[i].fd, tbl[i].rdy, tbl[i].fs, tbl[i].fen, tbl[i].vld,
           tbl[i].pd, tbl[i].sof, tbl[i].eol, tbl[i].fdn, $sformatf("stream%0d", i));
    end

    // Backpressure on pixel 0x0003
    resync();
    step(1, 32'h0004_0003, 1, 0, 1, 0, 16'h0, 0, 0, 0, "bp0");
    for (int i = 0; i < 3; i++) step(1, 32'h0006_0005, 0, 0, 0, 1, 16'h3, 1, 0, 0, $sformatf("bp_hold%0d", i));
    step(1, 32'h0006_0005, 1, 0, 0, 1, 16'h3, 1, 0, 0, "bp_rel");
    step(1, 32'h0006_0005, 1, 0, 1, 1, 16'h4, 0, 0, 0, "bp_next");

    // Starvation after the first word
    resync();
    step(1, 32'h0002_0001, 1, 0, 1, 0, 16'h0, 0, 0, 0, "sv0");
    step(0, 32'h0,         1, 0, 0, 1, 16'h1, 1, 0, 0, "sv1");
    step(0, 32'h0,         1, 0, 0, 1, 16'h2, 0, 0, 0, "sv2");
    step(0, 32'h0,         1, 0, 0, 0, 16'h0, 0, 0, 0, "sv_gap0");
    step(0, 32'h0,         1, 0, 0, 0, 16'h0, 0, 0, 0, "sv_gap1");
    step(1, 32'h0004_0003, 1, 0, 1, 0, 16'h0, 0, 0, 0, "sv_pop");
    step(0, 32'h0,         1, 0, 0, 1, 16'h3, 0, 0, 0, "sv3");
    step(0, 32'h0,         1, 0, 0, 1, 16'h4, 0, 1, 0, "sv4");

    // frame_sync while the upper half of 0x0004_0003 is showing
    resync();
    step(1, 32'h0004_0003, 1, 0, 1, 0, 16'h0, 0, 0, 0, "fs0");
    step(1, 32'h0006_0005, 1, 0, 0, 1, 16'h3, 1, 0, 0, "fs1");
    step(1, 32'h0006_0005, 0, 1, 0, 1, 16'h4, 0, 0, 0, "fs_pulse");
    step(1, 32'h0006_0005, 1, 0, 1, 0, 16'h0, 0, 0, 0, "fs_pop");
    step(1, 32'h0008_0007, 1, 0, 0, 1, 16'h5, 1, 0, 0, "fs_sof");

    // frame_sync coinciding with a last-lane accept
    resync();
    step(1, 32'h0002_0001, 1, 0, 1, 0, 16'h0, 0, 0, 0, "sim0");
    step(1, 32'h0004_0003, 1, 0, 0, 1, 16'h1, 1, 0, 0, "sim1");
    step(1, 32'h0004_0003, 1, 1, 0, 1, 16'h2, 0, 0, 0, "sim_sync");
    step(1, 32'h0004_0003, 1, 0, 1, 0, 16'h0, 0, 0, 0, "sim_pop");
    step(1, 32'h0006_0005, 1, 0, 0, 1, 16'h3, 1, 0, 0, "sim_sof");

    // Randomized traffic against a pixel-queue reference model
    resync();
    pos = 0;
    e_fd = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      while (fq.size() < 4) fq.push_back($urandom);
      drive(($urandom_range(0, 3) != 0), fq[0], ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
      e_vld = (exp_pix.size() > 0);
      e_fen = fifo_vld && !frame_sync && (exp_pix.size() == 0 || (pix_rdy && exp_pix.size() == 1));
      chk("rnd_pix_vld", pix_vld, e_vld);
      chk("rnd_fifo_en", fifo_en, e_fen);
      if (e_vld) chk("rnd_pix_data", pix_data, exp_pix[0]);
      chk("rnd_sof", pix_sof, e_vld && pos == 0);
      chk("rnd_eol", pix_eol, e_vld && (pos % H) == H - 1);
      chk("rnd_frame_done", frame_done, e_fd);
      e_acc = e_vld && pix_rdy;
      e_fd  = e_acc && pos == H * V - 1 && !frame_sync;
      if (e_acc) begin
        void'(exp_pix.pop_front());
        pos = (pos + 1) % (H * V);
      end
      if (frame_sync) begin
        exp_pix.delete();
        pos = 0;
      end
      if (e_fen) begin
        w = fq.pop_front();
        for (int k = 0; k < NL; k++) exp_pix.push_back(w[k*PW +: PW]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
